// File: rtl/data_mem_bridge_pkg.sv
// rtl/data_mem_bridge_pkg.sv - shared types and constants for the data-memory bus bridge
package data_mem_bridge_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic [3:0]            sel;
    logic                  we;
    logic [BUS_DATA_W-1:0] data;
  } mem_req_t;

  function automatic logic [BUS_ADDR_W-1:0] word_align(input logic [BUS_ADDR_W-1:0] a);
    return {a[BUS_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_store_buf.sv
// rtl/dmem_store_buf.sv - one-entry posted store buffer for the data-memory bridge
module dmem_store_buf
  import data_mem_bridge_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  mem_req_t push_req_i,
  input  logic     pop_i,
  output logic     valid_o,
  output mem_req_t req_o
);

  logic     valid_q;
  mem_req_t req_q;

  // Push and pop are never requested together: a push only happens with the buffer empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else if (push_i) begin
      valid_q <= 1'b1;
      req_q   <= push_req_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign req_o   = req_q;

endmodule

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - memory-stage request to split-handshake data bus bridge
// Optional posted store buffer enabled by defining DMEM_STORE_BUF_EN.
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              stallreq_o,
  output logic              req_o,
  output logic              wr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [3:0]        wstrb_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic              addr_ok_i,
  input  logic              data_ok_i,
  input  logic [DATA_W-1:0] rdata_i
);

  state_e            state_q, state_d;
  logic              cancel_q, cancel_d;
  mem_req_t          req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              stall;
  logic              buf_valid;
  mem_req_t          bus_req;

`ifdef DMEM_STORE_BUF_EN
  localparam bit POST_STORES = 1'b1;

  logic     buf_push, buf_pop;
  mem_req_t buf_req, push_req;

  assign push_req = '{addr: mem_addr_i, sel: mem_sel_i, we: 1'b1, data: mem_data_i};
  assign buf_push = (state_q == ST_IDLE) && mem_ce_i && mem_we_i && !flush_i;
  assign buf_pop  = (state_q == ST_DRAIN) && data_ok_i;

  dmem_store_buf u_store_buf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (buf_push),
    .push_req_i (push_req),
    .pop_i      (buf_pop),
    .valid_o    (buf_valid),
    .req_o      (buf_req)
  );

  // While a drain is in flight the bus carries the buffered store.
  assign bus_req = buf_valid ? buf_req : req_q;
`else
  localparam bit POST_STORES = 1'b0;

  assign buf_valid = 1'b0;
  assign bus_req   = req_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cancel_q <= 1'b0;
      req_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      req_q    <= req_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    stall    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_ce_i && !flush_i) begin
          state_d = ST_REQ;
          if (!(POST_STORES && mem_we_i)) begin
            req_d = '{addr: mem_addr_i, sel: mem_sel_i, we: mem_we_i, data: mem_data_i};
            stall = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stall = mem_ce_i;
        // A flush never cancels a buffered store.
        if (flush_i && !buf_valid) cancel_d = 1'b1;
        if (addr_ok_i) state_d = buf_valid ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        stall = mem_ce_i;
        if (flush_i) cancel_d = 1'b1;
        if (data_ok_i) begin
          if (cancel_q || flush_i) begin
            cancel_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            if (!req_q.we) rdata_d = rdata_i;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_DRAIN: begin
        stall = mem_ce_i;
        if (data_ok_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) stall = 1'b0;
  end

  assign stallreq_o  = stall && !rst;
  assign req_o       = (state_q == ST_REQ) && !rst;
  assign wr_o        = bus_req.we;
  assign addr_o      = word_align(bus_req.addr);
  assign wstrb_o     = bus_req.sel;
  assign wdata_o     = bus_req.data;
  assign mem_rdata_o = rdata_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb/tb_data_mem_bridge.sv - self-checking bench for data_mem_bridge
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce_i, mem_we_i, flush_i;
  logic [31:0] mem_addr_i, mem_data_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_rdata_o;
  logic        stallreq_o, req_o, wr_o;
  logic [31:0] addr_o, wdata_o;
  logic [3:0]  wstrb_o;
  logic        addr_ok_i, data_ok_i;
  logic [31:0] rdata_i;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  data_mem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_ce_i    (mem_ce_i),
    .mem_we_i    (mem_we_i),
    .mem_addr_i  (mem_addr_i),
    .mem_sel_i   (mem_sel_i),
    .mem_data_i  (mem_data_i),
    .flush_i     (flush_i),
    .mem_rdata_o (mem_rdata_o),
    .stallreq_o  (stallreq_o),
    .req_o       (req_o),
    .wr_o        (wr_o),
    .addr_o      (addr_o),
    .wstrb_o     (wstrb_o),
    .wdata_o     (wdata_o),
    .addr_ok_i   (addr_ok_i),
    .data_ok_i   (data_ok_i),
    .rdata_i     (rdata_i)
  );

  task automatic idle_cycle();
    @(negedge clk);
    mem_ce_i = 0; flush_i = 0; addr_ok_i = 0; data_ok_i = 0; rdata_i = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    tests++;
    if ({req_o, stallreq_o, wr_o, wstrb_o} !== 7'd0) begin
      fails++; $display("FAIL %s ctrl: got req=%b stall=%b wr=%b strb=%b expected all 0", tag, req_o, stallreq_o, wr_o, wstrb_o);
    end
    tests++;
    if ({addr_o, wdata_o, mem_rdata_o} !== 96'd0) begin
      fails++; $display("FAIL %s data: got addr=%h wdata=%h rdata=%h expected 0", tag, addr_o, wdata_o, mem_rdata_o);
    end
  endtask

  // One access from IDLE to its DONE cycle; addr_ok after a extra REQ cycles, data_ok d cycles later.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                            input logic [31:0] wd, input logic [31:0] rd, input int a, input int d,
                            input string tag);
    int req_cnt, stall_cnt, d_left;
    bit done;
    logic [31:0] exp_rdata, exp_addr;
    req_cnt = 0; stall_cnt = 0; d_left = 0; done = 0;
    exp_rdata = we ? model_rdata : rd;
    exp_addr  = {addr[31:2], 2'b00};
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      mem_ce_i = 1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = wd;
      flush_i = 0; addr_ok_i = 0; data_ok_i = 0; rdata_i = $urandom;
      if (d_left > 0) begin
        d_left--;
        if (d_left == 0) begin data_ok_i = 1; rdata_i = rd; end
      end
      #1;
      if (req_o) begin
        req_cnt++;
        tests++;
        if (addr_o !== exp_addr || wdata_o !== wd) begin
          fails++; $display("FAIL %s bus addr/data: got %h/%h expected %h/%h", tag, addr_o, wdata_o, exp_addr, wd);
        end
        tests++;
        if (wr_o !== we || wstrb_o !== sel) begin
          fails++; $display("FAIL %s bus wr/strb: got %b/%b expected %b/%b", tag, wr_o, wstrb_o, we, sel);
        end
        if (req_cnt == a + 1) begin addr_ok_i = 1; d_left = d; end
      end
      if (stallreq_o) stall_cnt++;
      else if (cyc > 0) begin
        done = 1;
        tests++;
        if (mem_rdata_o !== exp_rdata) begin
          fails++; $display("FAIL %s rdata: got %h expected %h", tag, mem_rdata_o, exp_rdata);
        end
      end
    end
    tests++;
    if (!done) begin
      fails++; $display("FAIL %s timeout: got no release expected DONE within 60 cycles", tag);
    end
    tests++;
    if (req_cnt != a + 1) begin
      fails++; $display("FAIL %s req cycles: got %0d expected %0d", tag, req_cnt, a + 1);
    end
    tests++;
    if (stall_cnt != 2 + a + d) begin
      fails++; $display("FAIL %s stall cycles: got %0d expected %0d", tag, stall_cnt, 2 + a + d);
    end
    if (!we) model_rdata = rd;
  endtask

  task automatic test_reset();
    rst = 1; mem_ce_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_sel_i = 0; mem_data_i = 0;
    flush_i = 0; addr_ok_i = 0; data_ok_i = 0; rdata_i = 0;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset_held");
    @(negedge clk); rst = 0;
    #1 check_all_zero("reset_released");
    model_rdata = 0;
  endtask

  task automatic test_zero_wait_load();
    run_access(0, 32'h1C02_0004, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 1, "zero_wait_load");
  endtask

  task automatic test_store_byte();
    run_access(1, 32'h1C02_0003, 4'b0001, 32'h5A5A_5A5A, 32'h0, 3, 1, "store_byte");
  endtask

  task automatic test_flush_wait();
    logic [31:0] old, rd_new;
    old = model_rdata; rd_new = $urandom;
    @(negedge clk);
    mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h0000_1008; mem_sel_i = 4'hF; mem_data_i = 0;
    @(negedge clk); #1;
    tests++;
    if (req_o !== 1'b1) begin fails++; $display("FAIL flush req: got %b expected 1", req_o); end
    addr_ok_i = 1;
    @(negedge clk); addr_ok_i = 0; flush_i = 1; #1;
    tests++;
    if (stallreq_o !== 1'b0) begin fails++; $display("FAIL flush stall: got %b expected 0", stallreq_o); end
    @(negedge clk); flush_i = 0; data_ok_i = 1; rdata_i = ~old; #1;
    tests++;
    if (stallreq_o !== 1'b1) begin fails++; $display("FAIL flush wait stall: got %b expected 1", stallreq_o); end
    @(negedge clk); data_ok_i = 0; #1;
    tests++;
    if (stallreq_o !== 1'b1) begin fails++; $display("FAIL flush no_done: got stall %b expected 1", stallreq_o); end
    tests++;
    if (mem_rdata_o !== old) begin fails++; $display("FAIL flush rdata kept: got %h expected %h", mem_rdata_o, old); end
    @(negedge clk); #1;
    tests++;
    if (req_o !== 1'b1) begin fails++; $display("FAIL flush reissue: got req %b expected 1", req_o); end
    addr_ok_i = 1;
    @(negedge clk); addr_ok_i = 0; data_ok_i = 1; rdata_i = rd_new;
    @(negedge clk); data_ok_i = 0; #1;
    tests++;
    if (stallreq_o !== 1'b0 || mem_rdata_o !== rd_new) begin
      fails++; $display("FAIL flush next load: got stall %b rdata %h expected 0 %h", stallreq_o, mem_rdata_o, rd_new);
    end
    model_rdata = rd_new;
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    logic [3:0] sels [7];
    sels = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
    for (int i = 0; i < 20; i++) begin
      logic we;
`ifdef DMEM_STORE_BUF_EN
      we = 0;
`else
      we = 1'($urandom_range(0, 1));
`endif
      run_access(we, $urandom, sels[$urandom_range(0, 6)], $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(1, 3), $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h1C00_0040; mem_sel_i = 4'hF; mem_data_i = 32'h1234_5678;
    @(negedge clk); #1;
    tests++;
    if (req_o !== 1'b1) begin fails++; $display("FAIL rst_mid req: got %b expected 1", req_o); end
    rst = 1;
    @(negedge clk); rst = 0; mem_ce_i = 0; #1;
    check_all_zero("rst_mid");
    model_rdata = 0;
    idle_cycle(); #1;
    tests++;
    if (req_o !== 1'b0) begin fails++; $display("FAIL rst_mid idle: got req %b expected 0", req_o); end
    run_access(0, 32'h1C00_0044, 4'hF, 32'h0, $urandom, 1, 2, "rst_mid_after");
    idle_cycle();
  endtask

`ifdef DMEM_STORE_BUF_EN
  task automatic test_store_buf();
    logic [31:0] rd;
    rd = $urandom;
    @(negedge clk);
    mem_ce_i = 1; mem_we_i = 1; mem_addr_i = 32'h0000_2002; mem_sel_i = 4'hC; mem_data_i = 32'hA5A5_0000; #1;
    tests++;
    if (stallreq_o !== 1'b0) begin fails++; $display("FAIL sb store stall: got %b expected 0", stallreq_o); end
    @(negedge clk);
    mem_we_i = 0; mem_addr_i = 32'h0000_3000; mem_sel_i = 4'hF; #1;
    tests++;
    if (req_o !== 1 || wr_o !== 1 || addr_o !== 32'h0000_2000 || wdata_o !== 32'hA5A5_0000 || stallreq_o !== 1) begin
      fails++; $display("FAIL sb drain: got req %b wr %b addr %h data %h stall %b expected 1 1 00002000 a5a50000 1", req_o, wr_o, addr_o, wdata_o, stallreq_o);
    end
    addr_ok_i = 1;
    @(negedge clk); addr_ok_i = 0; data_ok_i = 1; #1;
    tests++;
    if (stallreq_o !== 1 || req_o !== 0) begin fails++; $display("FAIL sb drain wait: got stall %b req %b expected 1 0", stallreq_o, req_o); end
    @(negedge clk); data_ok_i = 0; #1;
    tests++;
    if (stallreq_o !== 1 || req_o !== 0) begin fails++; $display("FAIL sb load latch: got stall %b req %b expected 1 0", stallreq_o, req_o); end
    @(negedge clk); #1;
    tests++;
    if (req_o !== 1 || wr_o !== 0 || addr_o !== 32'h0000_3000) begin
      fails++; $display("FAIL sb load req: got req %b wr %b addr %h expected 1 0 00003000", req_o, wr_o, addr_o);
    end
    addr_ok_i = 1;
    @(negedge clk); addr_ok_i = 0; data_ok_i = 1; rdata_i = rd;
    @(negedge clk); data_ok_i = 0; #1;
    tests++;
    if (stallreq_o !== 0 || mem_rdata_o !== rd) begin
      fails++; $display("FAIL sb load done: got stall %b rdata %h expected 0 %h", stallreq_o, mem_rdata_o, rd);
    end
    model_rdata = rd;
    idle_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait_load();
`ifdef DMEM_STORE_BUF_EN
    test_store_buf();
`else
    test_store_byte();
`endif
    test_flush_wait();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_bridge.md
# data_mem_bridge

Bridges the memory-access stage's combinational data-memory request (ce/we/addr/sel/data) onto the SRAM-like split-handshake data bus. Holds the pipeline with `stallreq_o` until the access completes. Returns load data to the memory stage for extraction and sign extension. Sits between the memory stage and the data-side bus interface; `stallreq_o` feeds the pipeline control block.

## Interface
Parameters:
- `ADDR_W`, 32, bus address width
- `DATA_W`, 32, bus data width

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `mem_ce_i`  in  1  access request from memory stage
- `mem_we_i`  in  1  1 = store, 0 = load (already exception-gated upstream)
- `mem_addr_i`  in  ADDR_W  byte address
- `mem_sel_i`  in  4  byte lanes, bit3 = data[31:24]
- `mem_data_i`  in  DATA_W  store data, byte/half already replicated
- `flush_i`  in  1  pipeline flush (exception/branch redirect)
- `mem_rdata_o`  out  DATA_W  load word returned to memory stage
- `stallreq_o`  out  1  hold IF..MEM stages
- `req_o`  out  1  bus request
- `wr_o`  out  1  bus write
- `addr_o`  out  ADDR_W  bus address, word-aligned (`[1:0]` = 0)
- `wstrb_o`  out  4  bus byte strobes (= `mem_sel_i`)
- `wdata_o`  out  DATA_W  bus write data
- `addr_ok_i`  in  1  bus accepted request
- `data_ok_i`  in  1  bus response (read data valid / write done)
- `rdata_i`  in  DATA_W  bus read data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE + `mem_ce_i`: latch addr/sel/we/data into request regs; `stallreq_o` = 1 (combinational); next state REQ.
- REQ: `req_o` = 1 with latched fields. `addr_ok_i` → WAIT. Once raised, `req_o` stays high until `addr_ok_i` regardless of flush.
- WAIT: `data_ok_i` → capture `rdata_i` into `mem_rdata_o` (loads only), next state DONE.
- DONE: `stallreq_o` = 0 for exactly one cycle so the pipeline advances; next state IDLE.
- `flush_i` in REQ/WAIT sets `cancel`. The handshake completes, then the FSM goes to IDLE directly, skipping DONE; `mem_rdata_o` is not updated.
- `stallreq_o` is forced 0 in the flush cycle. After that it is 1 whenever `mem_ce_i` is high and state ≠ IDLE/DONE.
- `flush_i` in IDLE/DONE: no effect on state; no new request is latched that cycle.
- `addr_o` = {addr[ADDR_W-1:2], 2'b00}. Sel/data pass unchanged.
- Bus rule: `data_ok_i` never asserts in the same cycle as `addr_ok_i` for the same request. A violation is ignored, and the FSM waits for the next `data_ok_i`.

## Timing
- Reset values: all outputs 0; state IDLE; `cancel` 0; store buffer empty.
- `rst` mid-transaction: state returns to IDLE immediately; outstanding bus response is ignored. The bus is reset together with the core.
- Zero-wait bus (`addr_ok` same cycle as `req`, `data_ok` next cycle): load occupies MEM for 4 cycles (IDLE, REQ, WAIT stalled; DONE released).
- `mem_rdata_o` is registered; it is valid in DONE and holds until the next captured load.

## Configuration
- `DMEM_STORE_BUF_EN` defined:
  - One-entry posted store buffer.
  - A store in IDLE with the buffer empty is written into the buffer; `stallreq_o` = 0 that cycle (store retires in 1 cycle).
  - The buffer drains through REQ/WAIT using state DRAIN semantics (no DONE, no stall).
  - A load or store arriving while the buffer is non-empty stalls until the drain's `data_ok_i`.
  - Flush never cancels a buffered store.
- Undefined: stores follow the load path (REQ/WAIT/DONE with stall); DRAIN is unreachable.

## Structure
- Shared package: FSM state encoding, `BUS_ADDR_W`/`BUS_DATA_W` constants, and the request struct {addr, sel, we, data}.
- Sub-module `dmem_store_buf`: the one-entry buffer (valid, fields, push/pop), instantiated only under `DMEM_STORE_BUF_EN`.

## Test plan
- Load `addr=0x1C02_0004`, bus zero-wait, `rdata=0xDEAD_BEEF` → `req_o` one cycle with `addr_o=0x1C02_0004`, `wr_o=0`, `stallreq_o` high 3 cycles, `mem_rdata_o=0xDEAD_BEEF` in DONE.
- Store byte, `addr=0x...0003`, `sel=0001`, `data=0x5A5A_5A5A`, `addr_ok` delayed 3 cycles → `req_o` held 4 cycles, `addr_o[1:0]=0`, `wstrb_o=0001`.
- `flush_i` in WAIT of a load → handshake completes, no DONE cycle, `mem_rdata_o` unchanged, `stallreq_o`=0 in the flush cycle.
- With `DMEM_STORE_BUF_EN`: store then immediate load → store: `stallreq_o`=0; load: stalls until the store's `data_ok`, then issues `req_o` with `wr_o=0`.
- `rst` asserted in REQ → next cycle all outputs 0, state IDLE; a later load completes normally.
